his_depth_packer: RTL and testbench
===================================

Name: his_depth_packer

Overview:
- Sits directly downstream of the histogram stage and consumes its per-pixel depth results (HIS_Odata / HIS_Ovalid / HIS_Oready).
- Range-checks each depth against TDC_Range and packs two 15-bit depths into one 32-bit word.
- Buffers packed words in a small first-word-fall-through FIFO.
- Emits the words as an AXI-stream frame to the core-logic readout, with TLAST on the last word of each frame.

Parameters:
- DW, 15, depth width; fixed to match HIS_Odata.
- FIFO_DEPTH, 8, packed-word FIFO entries; power of 2, minimum 2.
- FRAME_LEN, 16, depths per frame; even, minimum 2.

Ports:
- clk  input  1  250 MHz logic clock.
- rst  input  1  synchronous reset, active-high.
- HIS_Odata  input  15  depth value from histogram.
- HIS_Ovalid  input  1  depth valid.
- HIS_Oready  output  1  packer ready for a depth.
- TDC_Range  input  15  maximum legal depth.
- flush  input  1  one-cycle pulse; closes the current frame early.
- M_tdata  output  32  packed word.
- M_tvalid  output  1  word valid.
- M_tready  input  1  downstream ready.
- M_tlast  output  1  last word of frame.
- frame_cnt  output  8  frames delivered, wraps.
- clip_cnt  output  8  clipped depths, saturating.
- busy  output  1  partial word held or FIFO non-empty.

Behaviour:
- Reset (rst high at a clk edge):
  - state=LOW, frame index=0, FIFO empty.
  - M_tvalid=0, M_tlast=0, M_tdata=0, frame_cnt=0, clip_cnt=0, busy=0.
  - HIS_Oready=0 while rst is high.
  - Reset mid-frame discards the held depth and all FIFO contents with no output.
- Accept: a depth is accepted when HIS_Ovalid && HIS_Oready at a rising clk edge.
- Ready rule: HIS_Oready = !rst && !flush && !(state==HIGH && fifo_full).
  - In LOW, an accept only loads the hold register, so LOW accepts even when the FIFO is full.
- Clip:
  - If HIS_Odata > TDC_Range (unsigned), the stored depth is 15'h7FFF with flag=0; otherwise the depth is stored unchanged with flag=1.
  - clip_cnt increments per clipped accept and saturates at 255.
- State machine, two states:
  - LOW --accept--> HIGH: depth/flag latched as the low half.
  - HIGH --accept--> LOW: FIFO writes {flag_hi, depth_hi, flag_lo, depth_lo}, i.e. bits [31],[30:16],[15],[14:0].
  - Stored last bit = 1 when this word's high depth has frame index FRAME_LEN-1.
  - Frame index counts accepted depths 0..FRAME_LEN-1, then wraps to 0.
- Flush (priority over accept; ready is already low that cycle):
  - In HIGH: FIFO writes the partial word with the high half = 0 (flag_hi=0, depth 0) and last=1. State goes to LOW, frame index to 0.
    - If the FIFO is full in that cycle, the flush is held pending and the write completes on the first non-full cycle. HIS_Oready stays 0 until it completes.
  - In LOW with frame index != 0: the most recently written FIFO word is not altered. A zero word {32'h0} with last=1 is written, and frame index resets.
  - In LOW with frame index 0: no effect.
- FIFO:
  - FWFT; M_tvalid = !empty; M_tdata/M_tlast show the head entry; M_tdata=0 and M_tlast=0 when empty.
  - Pop on M_tvalid && M_tready.
  - Same-cycle push and pop are allowed in any non-empty state, and the occupancy is unchanged.
  - Latency: a word completed at edge N gives M_tvalid=1 after edge N when the FIFO was empty.
  - M_tdata is stable while M_tvalid && !M_tready (AXI-stream rule).
- frame_cnt increments on each pop with M_tlast=1 and wraps 255→0.
- busy = (state==HIGH) || !empty || flush pending.

Test Plan:
- Nominal frame: TDC_Range=15'h7FF8, M_tready=1, 16 depths 1..16 back-to-back → 8 words. Word0 = 32'h8002_8001; word7 = 32'h8010_800F with M_tlast=1; frame_cnt=1; clip_cnt=0.
- Clip: TDC_Range=100; depths 50,200 → word {0,7FFF,1,50} = 32'h7FFF_8032; clip_cnt=1. Then 300 clipped depths → clip_cnt saturates at 255.
- Backpressure: M_tready=0, 20 depths offered.
  - HIS_Oready drops after 8 words plus one held depth (17 accepts).
  - Releasing M_tready drains the words in order with M_tdata stable while stalled; the remaining 3 depths are then accepted.
- Flush:
  - Flush after 5 depths 1..5 → words 32'h8002_8001, 32'h8004_8003, 32'h0000_8005, the last with M_tlast=1; frame index restarts at 0.
  - Flush after 4 depths → extra word 32'h0000_0000 with tlast.
  - Flush with nothing pending → no word.
- Reset mid-operation: rst after 3 depths with the FIFO holding 1 word → next cycle M_tvalid=0, busy=0, counters 0. A following fresh 16-depth frame is output correctly.
- Simultaneous push/pop: FIFO at 7 entries, M_tready=1 while a word completes → occupancy stays 7, HIS_Oready stays 1, order preserved.

Source files
------------

// File: rtl/his_depth_packer.sv
// rtl/his_depth_packer.sv - packs range-checked histogram depths into 32-bit AXI-stream frames
//
// Purpose: takes per-pixel depths from the histogram stage, clips anything
// above TDC_Range, pairs two depths per 32-bit word, buffers words in a FWFT
// FIFO and streams them out with M_tlast on the final word of each frame.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   HIS_Odata/HIS_Ovalid/HIS_Oready   depth input handshake
//   TDC_Range                         largest legal depth (unsigned)
//   flush                             one-cycle pulse, closes the frame early
//   M_tdata/M_tvalid/M_tready/M_tlast packed-word output stream
//   frame_cnt                         frames delivered (wraps)
//   clip_cnt                          clipped depths (saturates at 255)
//   busy                              partial word held, FIFO non-empty or flush pending
module his_depth_packer #(
  parameter int DW         = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] HIS_Odata,
  input  logic          HIS_Ovalid,
  output logic          HIS_Oready,
  input  logic [DW-1:0] TDC_Range,
  input  logic          flush,
  output logic [31:0]   M_tdata,
  output logic          M_tvalid,
  input  logic          M_tready,
  output logic          M_tlast,
  output logic [7:0]    frame_cnt,
  output logic [7:0]    clip_cnt,
  output logic          busy
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            IW       = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {LOW, HIGH} state_t;

  state_t        state;
  logic [DW-1:0] lo_depth;
  logic          lo_flag;
  logic [IW-1:0] frame_idx;
  logic          flush_pend;

  // FIFO entry: {last, word[31:0]}
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          fifo_full, fifo_empty;
  logic          accept, in_clip, in_flag;
  logic [DW-1:0] in_depth;
  logic          flush_req, flush_need, flush_wr, pair_wr, push, pop;
  logic [32:0]   push_word;
  logic [32:0]   head;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  // A pending flush also blocks input so no depth slips in ahead of the
  // partial word that is still waiting for FIFO space.
  assign HIS_Oready = !rst && !flush && !flush_pend && !(state == HIGH && fifo_full);
  assign accept     = HIS_Ovalid && HIS_Oready;

  assign in_clip  = (HIS_Odata > TDC_Range);
  assign in_depth = in_clip ? {DW{1'b1}} : HIS_Odata;
  assign in_flag  = !in_clip;

  // A flush only produces a word when a frame is actually open: either a
  // low half is held, or an even number of depths of this frame went out.
  assign flush_req  = flush || flush_pend;
  assign flush_need = (state == HIGH) || (frame_idx != '0);
  assign flush_wr   = flush_req && flush_need && !fifo_full;
  // Exclusive with flush_wr: ready is low whenever a flush is requested.
  assign pair_wr    = accept && (state == HIGH);
  assign push       = flush_wr || pair_wr;
  assign pop        = !fifo_empty && M_tready;

  always_comb begin
    push_word = '0;
    if (flush_wr) begin
      if (state == HIGH) push_word = {1'b1, 1'b0, {DW{1'b0}}, lo_flag, lo_depth};
      else               push_word = {1'b1, 32'h0};
    end else begin
      // In HIGH, frame_idx is the index of the depth being accepted now.
      push_word = {(frame_idx == LAST_IDX), in_flag, in_depth, lo_flag, lo_depth};
    end
  end

  assign head     = mem[rd_ptr];
  assign M_tvalid = !fifo_empty;
  assign M_tdata  = fifo_empty ? 32'h0 : head[31:0];
  assign M_tlast  = fifo_empty ? 1'b0 : head[32];
  assign busy     = (state == HIGH) || !fifo_empty || flush_pend;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOW;
      lo_depth   <= '0;
      lo_flag    <= 1'b0;
      frame_idx  <= '0;
      flush_pend <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_cnt  <= '0;
      clip_cnt   <= '0;
    end else begin
      if (flush_req) begin
        if (flush_need && !fifo_full) begin
          state      <= LOW;
          frame_idx  <= '0;
          flush_pend <= 1'b0;
        end else begin
          flush_pend <= flush_need;
        end
      end else if (accept) begin
        if (in_clip && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 8'd1;
        frame_idx <= (frame_idx == LAST_IDX) ? '0 : frame_idx + 1'b1;
        if (state == LOW) begin
          lo_depth <= in_depth;
          lo_flag  <= in_flag;
          state    <= HIGH;
        end else begin
          state    <= LOW;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);

      if (pop && M_tlast) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_his_depth_packer.sv
// tb/tb_his_depth_packer.sv - scoreboard bench for his_depth_packer
module tb_his_depth_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] HIS_Odata;
  logic        HIS_Ovalid;
  logic        HIS_Oready;
  logic [14:0] TDC_Range;
  logic        flush;
  logic [31:0] M_tdata;
  logic        M_tvalid;
  logic        M_tready;
  logic        M_tlast;
  logic [7:0]  frame_cnt;
  logic [7:0]  clip_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  his_depth_packer #(.DW(15), .FIFO_DEPTH(8), .FRAME_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .HIS_Odata(HIS_Odata), .HIS_Ovalid(HIS_Ovalid), .HIS_Oready(HIS_Oready),
    .TDC_Range(TDC_Range), .flush(flush),
    .M_tdata(M_tdata), .M_tvalid(M_tvalid), .M_tready(M_tready), .M_tlast(M_tlast),
    .frame_cnt(frame_cnt), .clip_cnt(clip_cnt), .busy(busy)
  );

  always #2 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pair_ok(input int lo, input int hi);
    logic [14:0] l, h;
    l = 15'(lo);
    h = 15'(hi);
    return {1'b1, h, 1'b1, l};
  endfunction

  task automatic push_exp(input logic last, input logic [31:0] d);
    exp_q.push_back({last, d});
  endtask

  // Monitor: compare every popped word against the scoreboard head and
  // verify the head holds still while stalled.
  logic        stalled = 1'b0;
  logic [32:0] held = '0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && M_tvalid) chk("stall_stable", {M_tlast, M_tdata}, held);
      if (M_tvalid && M_tready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_word: got %h expected none", {M_tlast, M_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("word", {M_tlast, M_tdata}, e);
        end
      end
      stalled = M_tvalid && !M_tready;
      held    = {M_tlast, M_tdata};
    end
  end

  // Called and returns at posedge+1.
  task automatic send_depth(input int d, input int max_wait, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    HIS_Odata  = 15'(d);
    HIS_Ovalid = 1'b1;
    while (!ok && n < max_wait) begin
      @(negedge clk);
      if (HIS_Oready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        n++;
      end
    end
    HIS_Ovalid = 1'b0;
    if (!ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ok(input int d);
    bit ok;
    send_depth(d, 50, ok);
    chk("accept", {32'h0, ok}, 33'h1);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    chk("ready_low_on_flush", {32'h0, HIS_Oready}, 33'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", {32'h0, (n < 500)}, 33'h1);
  endtask

  initial begin
    bit ok;
    int acc;

    rst = 1'b1; HIS_Odata = '0; HIS_Ovalid = 1'b0; TDC_Range = 15'h7FF8;
    flush = 1'b0; M_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {32'h0, HIS_Oready}, 33'h0);
    chk("rst_tvalid", {32'h0, M_tvalid}, 33'h0);
    chk("rst_tdata",  {1'b0, M_tdata}, 33'h0);
    chk("rst_tlast",  {32'h0, M_tlast}, 33'h0);
    chk("rst_counts", {17'h0, frame_cnt, clip_cnt}, 33'h0);
    chk("rst_busy",   {32'h0, busy}, 33'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal 16-depth frame
    M_tready = 1'b1;
    push_exp(1'b0, 32'h8002_8001);
    for (int k = 1; k < 7; k++) push_exp(1'b0, pair_ok(2*k+1, 2*k+2));
    push_exp(1'b1, 32'h8010_800F);
    for (int d = 1; d <= 16; d++) send_ok(d);
    wait_drain();
    chk("nominal_frame_cnt", {25'h0, frame_cnt}, 33'd1);
    chk("nominal_clip_cnt",  {25'h0, clip_cnt}, 33'd0);

    // Clipping and saturation; frame index starts at 0 here
    TDC_Range = 15'd100;
    push_exp(1'b0, 32'h7FFF_8032);
    send_ok(50);
    send_ok(200);
    chk("clip_one", {25'h0, clip_cnt}, 33'd1);
    // Pair j holds indices 2+2j, 3+2j; it closes a frame when 3+2j = 15 mod 16.
    for (int j = 0; j < 150; j++) push_exp((j % 8) == 6, 32'h7FFF_7FFF);
    push_exp(1'b1, 32'h0000_0000);
    for (int i = 0; i < 300; i++) send_ok(1000);
    flush_pulse();
    wait_drain();
    chk("clip_saturate", {25'h0, clip_cnt}, 33'd255);
    chk("clip_frame_cnt", {25'h0, frame_cnt}, 33'd20);

    // Backpressure: 20 depths offered with the output stalled
    TDC_Range = 15'h7FF8;
    M_tready = 1'b0;
    for (int k = 0; k < 10; k++) push_exp(k == 7, pair_ok(101 + 2*k, 102 + 2*k));
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send_depth(101 + i, 6, ok);
      if (!ok) break;
      acc++;
    end
    chk("bp_accepts", 33'(acc), 33'd17);
    chk("bp_ready_low", {32'h0, HIS_Oready}, 33'h0);
    chk("bp_head", {M_tlast, M_tdata}, {1'b0, 32'h0066_8065} | 33'h0000_8000 | 33'h8000_0000);
    M_tready = 1'b1;
    for (int d = 118; d <= 120; d++) send_ok(d);
    // Four depths of the new frame are out; flush in LOW emits a zero word.
    push_exp(1'b1, 32'h0000_0000);
    flush_pulse();
    wait_drain();
    chk("bp_frame_cnt", {25'h0, frame_cnt}, 33'd22);

    // Flush after 5 depths
    push_exp(1'b0, 32'h8002_8001);
    push_exp(1'b0, 32'h8004_8003);
    push_exp(1'b1, 32'h0000_8005);
    for (int d = 1; d <= 5; d++) send_ok(d);
    flush_pulse();
    wait_drain();
    chk("flush5_frame_cnt", {25'h0, frame_cnt}, 33'd23);

    // Flush with nothing pending
    flush_pulse();
    repeat (4) @(posedge clk);
    #1;
    chk("empty_flush_tvalid", {32'h0, M_tvalid}, 33'h0);
    chk("empty_flush_busy",   {32'h0, busy}, 33'h0);
    chk("empty_flush_frames", {25'h0, frame_cnt}, 33'd23);

    // Flush in HIGH with a full FIFO is held pending
    M_tready = 1'b0;
    for (int k = 0; k < 8; k++) push_exp(k == 7, pair_ok(2*k+1, 2*k+2));
    push_exp(1'b1, 32'h0000_8011);
    for (int d = 1; d <= 17; d++) send_ok(d);
    flush_pulse();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pend_busy",  {32'h0, busy}, 33'h1);
    chk("pend_ready", {32'h0, HIS_Oready}, 33'h0);
    @(posedge clk);
    #1;
    M_tready = 1'b1;
    wait_drain();
    chk("pend_frame_cnt", {25'h0, frame_cnt}, 33'd25);
    @(negedge clk);
    chk("pend_ready_back", {32'h0, HIS_Oready}, 33'h1);
    @(posedge clk);
    #1;

    // Reset mid-frame: held depth and one buffered word are discarded
    M_tready = 1'b0;
    for (int d = 1; d <= 3; d++) send_ok(d);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", {32'h0, M_tvalid}, 33'h0);
    chk("mid_rst_busy",   {32'h0, busy}, 33'h0);
    chk("mid_rst_counts", {17'h0, frame_cnt, clip_cnt}, 33'h0);
    @(posedge clk);
    #1;
    M_tready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(k == 7, pair_ok(201 + 2*k, 202 + 2*k));
    for (int d = 201; d <= 216; d++) send_ok(d);
    wait_drain();
    chk("post_rst_frame_cnt", {25'h0, frame_cnt}, 33'd1);

    // Simultaneous push and pop at 7 entries
    M_tready = 1'b0;
    for (int k = 0; k < 10; k++) push_exp(k == 7, pair_ok(301 + 2*k, 302 + 2*k));
    for (int d = 301; d <= 315; d++) send_ok(d);
    M_tready = 1'b1;
    send_ok(316);
    M_tready = 1'b0;
    @(negedge clk);
    chk("pp_ready", {32'h0, HIS_Oready}, 33'h1);
    @(posedge clk);
    #1;
    send_ok(317);
    send_ok(318);
    send_ok(319);
    send_depth(320, 4, ok);
    chk("pp_full_refuse", {32'h0, ok}, 33'h0);
    M_tready = 1'b1;
    send_ok(320);
    wait_drain();
    chk("pp_frame_cnt", {25'h0, frame_cnt}, 33'd2);
    chk("queue_empty", 33'(exp_q.size()), 33'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
